// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and image table for the LED matrix row driver.
package matrix_pkg;

    localparam int unsigned ROWS      = 7;
    localparam int unsigned HALF_COLS = 3;
    localparam int unsigned IMAGES    = 8;
    localparam int unsigned IMG_W     = 3;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned COL_W     = 3;

    localparam logic [ROWS-1:0] ROW_OFF = 7'h7F;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        SHOW  = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Active-high pixel patterns; index 0 and 2 are the mirrored outer column pairs.
    localparam logic [ROWS-1:0] IMAGE_ROM [IMAGES][HALF_COLS] = '{
        '{7'h00, 7'h00, 7'h00},   // 0: blank
        '{7'h1C, 7'h22, 7'h41},   // 1: water drop
        '{7'h08, 7'h14, 7'h7F},   // 2: valve open
        '{7'h3E, 7'h41, 7'h49},   // 3: valve closed
        '{7'h70, 7'h0E, 7'h01},   // 4: flow rising
        '{7'h7F, 7'h41, 7'h5D},   // 5: tank full
        '{7'h11, 7'h2A, 7'h44},   // 6: low pressure
        '{7'h63, 7'h14, 7'h08}    // 7: fault cross
    };

    // One-hot column select to ROM column index; non-one-hot maps to 0 (never displayed).
    function automatic logic [IDX_W-1:0] col_to_idx(input logic [COL_W-1:0] c);
        logic [IDX_W-1:0] idx;
        idx = '0;
        case (c)
            3'b100:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b001:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/matrix_image_rom.sv
// Combinational image lookup: (image, column index) -> active-high row pattern.
module matrix_image_rom
    import matrix_pkg::*;
(
    input  logic [IMG_W-1:0] img,
    input  logic [IDX_W-1:0] idx,
    output logic [ROWS-1:0]  pattern_c
);

    // Table read with the unused fourth index forced blank.
    always_comb begin
        pattern_c = '0;
        if (idx < IDX_W'(HALF_COLS)) begin
            pattern_c = IMAGE_ROM[img][idx];
        end
    end

endmodule

// File: rtl/matrix_row_driver.sv
// Row driver for a multiplexed LED matrix: column-change blanking, frame-locked
// image selection, optional blinking and sticky detection of bad column codes.
module matrix_row_driver
    import matrix_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [COL_W-1:0] col,
    input  logic [IMG_W-1:0] image_sel,
    input  logic             blink_en,
    output logic [ROWS-1:0]  row,
    output logic             frame_start,
    output logic             col_error
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FCNT_W = 8;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [COL_W-1:0]    col_q;
    logic [IMG_W-1:0]    img_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                blink_phase;
    logic                col_ok_c;
    logic                col_change_c;
    logic                frame_edge_c;
    logic [ROWS-1:0]     pattern_c;
    logic [ROWS-1:0]     row_d;

    matrix_image_rom u_rom (
        .img       (img_q),
        .idx       (col_to_idx(col_q)),
        .pattern_c (pattern_c)
    );

    // Column validity and change detection against the previous cycle's column.
    always_comb begin
        col_ok_c     = $onehot(col);
        col_change_c = (col != col_q);
        frame_edge_c = col_ok_c && col_change_c && (col == 3'b100);
    end

    // Next state: bad column wins, then column change restarts blanking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!col_ok_c) begin
            state_d = FAULT;
        end else if (col_change_c) begin
            state_d = BLANK;
            cnt_d   = CNT_W'(BLANK_CYCLES - 1);
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = SHOW;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SHOW:    state_d = SHOW;
                FAULT:   state_d = FAULT;
                default: state_d = FAULT;
            endcase
        end
    end

    // Row drive follows the next state so the pattern lands right as SHOW begins.
    always_comb begin
        row_d = ROW_OFF;
        if ((state_d == SHOW) && !(blink_en && blink_phase)) begin
            row_d = ~pattern_c;
        end
    end

    // State, blank counter and column/image capture registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BLANK;
            cnt_q   <= CNT_W'(BLANK_CYCLES - 1);
            col_q   <= '0;
            img_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col;
            if (frame_edge_c) begin
                img_q <= image_sel;
            end
        end
    end

    // Registered outputs: row drive, frame pulse and sticky column error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row         <= ROW_OFF;
            frame_start <= 1'b0;
            col_error   <= 1'b0;
        end else begin
            row         <= row_d;
            frame_start <= frame_edge_c;
            if (!col_ok_c) begin
                col_error <= 1'b1;
            end
        end
    end

    // Blink timing: count frames per half period, toggle phase on wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_q      <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            fcnt_q      <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                fcnt_q      <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_row_driver.sv
// Directed bench for matrix_row_driver: vector table plus blink and reset sequences.
module tb_matrix_row_driver;

    logic       clock;
    logic       reset_n;
    logic [2:0] col;
    logic [2:0] image_sel;
    logic       blink_en;
    logic [6:0] row;
    logic       frame_start;
    logic       col_error;

    int tests;
    int fails;

    matrix_row_driver #(
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .col         (col),
        .image_sel   (image_sel),
        .blink_en    (blink_en),
        .row         (row),
        .frame_start (frame_start),
        .col_error   (col_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] col;
        logic [2:0] sel;
        logic [6:0] row;
        logic       fs;
        logic       err;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0] colv [3];
        logic [6:0] img1 [3];
        logic       on;

        tests = 0;
        fails = 0;
        colv[0] = 3'b100; colv[1] = 3'b010; colv[2] = 3'b001;
        img1[0] = 7'h63;  img1[1] = 7'h5D;  img1[2] = 7'h3E;

        // Column rotation with mid-frame image change, bad column, change during blanking.
        vecs[0]  = '{3'b100, 3'd1, 7'h7F, 1'b1, 1'b0};
        vecs[1]  = '{3'b100, 3'd1, 7'h7F, 1'b0, 1'b0};
        vecs[2]  = '{3'b100, 3'd1, 7'h63, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 3'd1, 7'h63, 1'b0, 1'b0};
        vecs[4]  = '{3'b010, 3'd1, 7'h7F, 1'b0, 1'b0};
        vecs[5]  = '{3'b010, 3'd1, 7'h7F, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 3'd1, 7'h5D, 1'b0, 1'b0};
        vecs[7]  = '{3'b010, 3'd2, 7'h5D, 1'b0, 1'b0};
        vecs[8]  = '{3'b001, 3'd2, 7'h7F, 1'b0, 1'b0};
        vecs[9]  = '{3'b001, 3'd2, 7'h7F, 1'b0, 1'b0};
        vecs[10] = '{3'b001, 3'd2, 7'h3E, 1'b0, 1'b0};
        vecs[11] = '{3'b100, 3'd2, 7'h7F, 1'b1, 1'b0};
        vecs[12] = '{3'b100, 3'd2, 7'h7F, 1'b0, 1'b0};
        vecs[13] = '{3'b100, 3'd2, 7'h77, 1'b0, 1'b0};
        vecs[14] = '{3'b010, 3'd2, 7'h7F, 1'b0, 1'b0};
        vecs[15] = '{3'b010, 3'd2, 7'h7F, 1'b0, 1'b0};
        vecs[16] = '{3'b010, 3'd2, 7'h6B, 1'b0, 1'b0};
        vecs[17] = '{3'b001, 3'd2, 7'h7F, 1'b0, 1'b0};
        vecs[18] = '{3'b001, 3'd2, 7'h7F, 1'b0, 1'b0};
        vecs[19] = '{3'b001, 3'd2, 7'h00, 1'b0, 1'b0};
        vecs[20] = '{3'b011, 3'd2, 7'h7F, 1'b0, 1'b1};
        vecs[21] = '{3'b100, 3'd2, 7'h7F, 1'b1, 1'b1};
        vecs[22] = '{3'b100, 3'd2, 7'h7F, 1'b0, 1'b1};
        vecs[23] = '{3'b100, 3'd2, 7'h77, 1'b0, 1'b1};
        vecs[24] = '{3'b010, 3'd2, 7'h7F, 1'b0, 1'b1};
        vecs[25] = '{3'b001, 3'd2, 7'h7F, 1'b0, 1'b1};
        vecs[26] = '{3'b001, 3'd2, 7'h7F, 1'b0, 1'b1};
        vecs[27] = '{3'b001, 3'd2, 7'h00, 1'b0, 1'b1};

        // Reset values.
        reset_n   = 1'b0;
        col       = 3'b100;
        image_sel = 3'd1;
        blink_en  = 1'b0;
        #12;
        check("reset_row", row, 7'h7F);
        check("reset_fs", 7'(frame_start), 7'h0);
        check("reset_err", 7'(col_error), 7'h0);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            col       = vecs[i].col;
            image_sel = vecs[i].sel;
            tick();
            check($sformatf("vec%0d_row", i), row, vecs[i].row);
            check($sformatf("vec%0d_fs", i), 7'(frame_start), 7'(vecs[i].fs));
            check($sformatf("vec%0d_err", i), 7'(col_error), 7'(vecs[i].err));
        end

        // Held column keeps showing.
        for (int i = 0; i < 20; i++) tick();
        check("persist_row", row, 7'h00);

        // Blinking: enabled just after frame 0 has been counted off, two frames per half period.
        image_sel = 3'd1;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 3; c++) begin
                col = colv[c];
                for (int k = 0; k < 4; k++) begin
                    tick();
                    if (c == 0 && k == 0)
                        check($sformatf("blink_f%0d_fs", f), 7'(frame_start), 7'h1);
                    if (f == 0 && c == 0 && k == 1)
                        blink_en = 1'b1;
                end
                on = ((f / 2) % 2) == 0;
                check($sformatf("blink_f%0d_c%0d", f, c), row, on ? img1[c] : 7'h7F);
            end
        end

        // Blink off clears the phase; column 001 shows again.
        blink_en = 1'b0;
        tick();
        tick();
        check("unblink_row", row, 7'h3E);

        // Asynchronous reset mid-SHOW.
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_row", row, 7'h7F);
        check("async_rst_err", 7'(col_error), 7'h0);
        check("async_rst_fs", 7'(frame_start), 7'h0);
        tick();
        check("rst_hold_row", row, 7'h7F);
        reset_n = 1'b1;

        // First column after reset counts as a change; image reset to blank.
        for (int k = 0; k < 3; k++) tick();
        check("post_rst_blank_img", row, 7'h7F);
        check("post_rst_no_fs", 7'(frame_start), 7'h0);
        col       = 3'b100;
        image_sel = 3'd3;
        tick();
        check("post_rst_fs", 7'(frame_start), 7'h1);
        tick();
        check("post_rst_blanking", row, 7'h7F);
        tick();
        check("post_rst_img3", row, 7'h41);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
